hack_cpu_mc: RTL and testbench
==============================

HACK_CPU_MC -- requirements
Module: hack_cpu_mc

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning register, ALU and instruction width; legal range is 16 or more.
REQ-002 The block SHALL have parameter ADDR_W, default 15, meaning instruction and data address width; legal range is 1 to DATA_W-1.
REQ-003 The block SHALL have parameter RESET_PC, default 0, meaning the PC value loaded on reset.
REQ-004 Port clk SHALL be: clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 Port reset SHALL be: reset  in  1  synchronous, active-high reset.
REQ-006 Port instr_req SHALL be: instr_req  out  1  instruction fetch request.
REQ-007 Port instr_addr SHALL be: instr_addr  out  ADDR_W  fetch address; always equals pc.
REQ-008 Port instr_valid SHALL be: instr_valid  in  1  instr_data is valid this cycle.
REQ-009 Port instr_data SHALL be: instr_data  in  DATA_W  fetched instruction.
REQ-010 Port mem_req SHALL be: mem_req  out  1  data memory request.
REQ-011 Port mem_we SHALL be: mem_we  out  1  1 = write, 0 = read; qualified by mem_req.
REQ-012 Port mem_addr SHALL be: mem_addr  out  ADDR_W  data address; equals A[ADDR_W-1:0] as it was at instruction start.
REQ-013 Port mem_wdata SHALL be: mem_wdata  out  DATA_W  registered ALU result to write.
REQ-014 Port mem_rdata SHALL be: mem_rdata  in  DATA_W  read data; valid when mem_ack=1.
REQ-015 Port mem_ack SHALL be: mem_ack  in  1  completes the current data request.
REQ-016 Port pc SHALL be: pc  out  ADDR_W  address of the instruction currently being fetched or executed.
REQ-017 Port retired SHALL be: retired  out  1  one-cycle pulse in each instruction's commit cycle.
REQ-018 Port halted SHALL be: halted  out  1  core stopped on an illegal instruction.

Function
REQ-019 The FSM SHALL have states FETCH, RDMEM, EXEC, WRMEM and HALT; HALT exists only under the macro.
REQ-020 In FETCH, instr_req SHALL be 1; on instr_valid=1 the block SHALL latch IR. Next state: RDMEM if the instruction is a C-instruction with bit12=1, otherwise EXEC.
REQ-021 instr_data SHALL be ignored when the block is outside FETCH or when instr_valid=0.
REQ-022 In RDMEM, mem_req SHALL be 1 and mem_we SHALL be 0, held until mem_ack=1; on mem_ack the block SHALL latch MDR from mem_rdata and go to EXEC.
REQ-023 Decode SHALL be: bit[DATA_W-1]=0 is an A-instruction, loading A with zero-extended IR[DATA_W-2:0]; bit[DATA_W-1]=1 is a C-instruction.
REQ-024 C-instruction fields SHALL be fixed at the low 13 bits:
- a = bit12
- zx, nx, zy, ny, f, no = bits 11..6
- d1 (A), d2 (D), d3 (M) = bits 5..3
- j1, j2, j3 = bits 2..0
REQ-025 The ALU SHALL take x=D and y=(a ? MDR : A), apply the standard Hack zx/nx/zy/ny/f/no sequence at DATA_W bits, and discard the carry of the addition.
REQ-026 Flags SHALL be: zr = (out==0); ng = out[DATA_W-1]. Jump = (j1&ng) | (j2&zr) | (j3&!ng&!zr).
REQ-027 In EXEC, if d3=1 the block SHALL register the ALU result into mem_wdata and go to WRMEM; otherwise it SHALL commit and go to FETCH.
REQ-028 In WRMEM, mem_req=1 and mem_we=1 SHALL be held with constant addr and wdata until mem_ack=1; the block SHALL then commit and go to FETCH.
REQ-029 Commit SHALL occur in one cycle and SHALL:
- load A if d1 or if the instruction is an A-instruction;
- load D if d2;
- set pc = jump ? old A[ADDR_W-1:0] : pc+1, wrapping modulo 2^ADDR_W;
- pulse retired=1.
REQ-030 Jump target and mem_addr SHALL use the A value from before the commit, even when d1=1.
REQ-031 Latency with zero-wait memories SHALL be:
- A-instruction or plain C-instruction: 2 cycles;
- C-instruction with a=1: 3 cycles;
- C-instruction with a=1 and d3=1: 4 cycles.
REQ-032 mem_req SHALL be 0 in FETCH and EXEC; instr_req SHALL be 0 outside FETCH.
REQ-033 mem_ack outside RDMEM and WRMEM SHALL be ignored.

Reset
REQ-034 reset=1 SHALL force, at the next edge, from any state including mid-handshake:
- state = FETCH
- A = 0, D = 0, IR = 0, MDR = 0, mem_wdata = 0
- pc = RESET_PC
REQ-035 A pending memory transaction SHALL be abandoned on reset with no commit.
REQ-036 In the first cycle after reset: instr_req=1, instr_addr=RESET_PC, mem_req=0, mem_we=0, retired=0, halted=0.

Configuration
REQ-037 With HACK_CPU_ILLEGAL_HALT_EN defined, a C-instruction whose bits[14:13] are not 2'b11 SHALL go from FETCH to HALT with no commit.
REQ-038 In HALT the block SHALL hold halted=1, instr_req=0, mem_req=0 and pc unchanged, until reset.
REQ-039 With HACK_CPU_ILLEGAL_HALT_EN undefined, bits[14:13] SHALL be ignored, halted SHALL be tied to 0, and no HALT state SHALL exist.

Verification
REQ-040 Zero-wait memories, program @5, D=A, @3, D=D+A SHALL yield D=8, pc=4 and exactly 4 retired pulses within 8 cycles.
REQ-041 With A=7, M=D with D=9, and mem_ack delayed 3 cycles SHALL hold mem_req=1, mem_we=1, addr=7, wdata=9 for 4 cycles, then retire once with pc+1.
REQ-042 With A=2, AM=M+1 where RAM[2]=10 SHALL read addr 2, write 11 to addr 2, and leave A=11.
REQ-043 With A=20, D=0, D;JEQ at pc=4 SHALL set pc=20; with D=-1 the same instruction SHALL set pc=5; with ADDR_W=4, pc=15 with no jump SHALL wrap pc to 0.
REQ-044 Reset asserted during a WRMEM wait SHALL drop mem_req the next cycle, produce no retired pulse, and give pc=RESET_PC, A=D=0.
REQ-045 With the macro defined, fetching 16'h9000 SHALL raise halted=1, leave A, D and pc unchanged, and keep instr_req=0 until reset.

Source files
------------

// File: rtl/hack_cpu_mc.sv
`default_nettype none
// ============================================================================
// Module      : hack_cpu_mc
// Description : Multi-cycle Hack CPU. Separate instruction fetch and data
//               memory request/ack handshakes; FSM sequences FETCH, RDMEM
//               (M operand read), EXEC and WRMEM (M store).
//               Optional macro HACK_CPU_ILLEGAL_HALT_EN adds a HALT state
//               entered on C-instructions whose bits[14:13] are not 2'b11.
// Revision    : 1.0 - initial release
// ============================================================================
module hack_cpu_mc #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 15,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              instr_req,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] instr_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              retired,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] c_RESET_PC = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] c_PC_ONE   = ADDR_W'(1);

`ifdef HACK_CPU_ILLEGAL_HALT_EN
  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_RDMEM = 3'd1,
    S_EXEC  = 3'd2,
    S_WRMEM = 3'd3,
    S_HALT  = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_RDMEM = 2'd1,
    S_EXEC  = 2'd2,
    S_WRMEM = 2'd3
  } state_t;
`endif

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_d;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_mdr;
  logic [DATA_W-1:0] r_wdata;
  logic [ADDR_W-1:0] r_pc;

  logic w_ld_ir;
  logic w_ld_mdr;
  logic w_ld_wdata;
  logic w_commit;

  // Decode of the latched instruction; C fields sit in the low 13 bits
  logic w_is_c;
  assign w_is_c = r_ir[DATA_W-1];

  logic [DATA_W-1:0] w_x0, w_x1, w_y0, w_y1, w_y2, w_fo, w_alu;
  logic              w_zr, w_ng, w_jump;

  // Hack ALU: x = D, y = A or MDR, zx/nx/zy/ny/f/no applied in order
  always_comb begin
    w_x0  = r_ir[11] ? '0 : r_d;
    w_x1  = r_ir[10] ? ~w_x0 : w_x0;
    w_y0  = r_ir[12] ? r_mdr : r_a;
    w_y1  = r_ir[9] ? '0 : w_y0;
    w_y2  = r_ir[8] ? ~w_y1 : w_y1;
    w_fo  = r_ir[7] ? (w_x1 + w_y2) : (w_x1 & w_y2);
    w_alu = r_ir[6] ? ~w_fo : w_fo;
  end

  assign w_zr   = (w_alu == '0);
  assign w_ng   = w_alu[DATA_W-1];
  assign w_jump = w_is_c & ((r_ir[2] & w_ng) | (r_ir[1] & w_zr) | (r_ir[0] & ~w_ng & ~w_zr));

`ifdef HACK_CPU_ILLEGAL_HALT_EN
  logic w_illegal_fetch;
  assign w_illegal_fetch = instr_data[DATA_W-1] & (instr_data[14:13] != 2'b11);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, handshake outputs and datapath load strobes
  always_comb begin
    w_state_nxt = r_state;
    instr_req   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    w_ld_ir     = 1'b0;
    w_ld_mdr    = 1'b0;
    w_ld_wdata  = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_FETCH: begin
        instr_req = 1'b1;
        if (instr_valid) begin
          w_ld_ir = 1'b1;
          if (instr_data[DATA_W-1] && instr_data[12]) begin
            w_state_nxt = S_RDMEM;
          end else begin
            w_state_nxt = S_EXEC;
          end
`ifdef HACK_CPU_ILLEGAL_HALT_EN
          if (w_illegal_fetch) begin
            w_state_nxt = S_HALT;
          end
`endif
        end
      end
      S_RDMEM: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          w_ld_mdr    = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_is_c && r_ir[3]) begin
          w_ld_wdata  = 1'b1;
          w_state_nxt = S_WRMEM;
        end else begin
          w_commit    = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_WRMEM: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          w_commit    = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
`ifdef HACK_CPU_ILLEGAL_HALT_EN
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
`endif
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  // Datapath registers; A/D/PC change only in the commit cycle so the
  // jump target and data address always see the pre-commit A
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_d     <= '0;
      r_ir    <= '0;
      r_mdr   <= '0;
      r_wdata <= '0;
      r_pc    <= c_RESET_PC;
    end else begin
      if (w_ld_ir) begin
        r_ir <= instr_data;
      end
      if (w_ld_mdr) begin
        r_mdr <= mem_rdata;
      end
      if (w_ld_wdata) begin
        r_wdata <= w_alu;
      end
      if (w_commit) begin
        if (!w_is_c) begin
          r_a <= {1'b0, r_ir[DATA_W-2:0]};
        end else begin
          if (r_ir[5]) begin
            r_a <= w_alu;
          end
          if (r_ir[4]) begin
            r_d <= w_alu;
          end
        end
        r_pc <= w_jump ? r_a[ADDR_W-1:0] : (r_pc + c_PC_ONE);
      end
    end
  end

  assign instr_addr = r_pc;
  assign pc         = r_pc;
  assign mem_addr   = r_a[ADDR_W-1:0];
  assign mem_wdata  = r_wdata;
  // A reset landing on a commit cycle abandons the instruction
  assign retired    = w_commit & ~reset;

`ifdef HACK_CPU_ILLEGAL_HALT_EN
  assign halted = (r_state == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hack_cpu_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_hack_cpu_mc
// Description : Self-checking bench for hack_cpu_mc. Instruction-level
//               reference model (A, D, PC, RAM) predicts per-instruction
//               memory traffic, latency and resulting PC.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hack_cpu_mc;

  logic        clk;
  logic        reset;
  logic        instr_req;
  logic [14:0] instr_addr;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic        mem_req;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [14:0] pc;
  logic        retired;
  logic        halted;

  hack_cpu_mc dut (
    .clk        (clk),
    .reset      (reset),
    .instr_req  (instr_req),
    .instr_addr (instr_addr),
    .instr_valid(instr_valid),
    .instr_data (instr_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .pc         (pc),
    .retired    (retired),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference machine state
  logic [15:0] m_a, m_d;
  logic [14:0] m_pc;
  logic [15:0] ram [0:32767];

  logic [15:0] last_wdata;
  logic [14:0] last_waddr;
  int          last_cycles;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_alu(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
    logic [15:0] xx, yy, r;
    xx = c[5] ? 16'd0 : x;
    if (c[4]) xx = 16'hFFFF - xx;
    yy = c[3] ? 16'd0 : y;
    if (c[2]) yy = 16'hFFFF - yy;
    r = c[1] ? 16'(xx + yy) : (xx & yy);
    if (c[0]) r = 16'hFFFF - r;
    return r;
  endfunction

  task automatic do_reset();
    reset       = 1'b1;
    instr_valid = 1'b0;
    mem_ack     = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_a = 16'd0; m_d = 16'd0; m_pc = 15'd0;
  endtask

  // Run one instruction through the DUT; entry/exit at posedge+1 in FETCH
  task automatic do_instr(input logic [15:0] ins, input int fwait, input int mwait);
    logic [14:0] addr, new_pc;
    logic [15:0] y, out;
    logic        is_c, jmp;
    int exp_rd, exp_wr, exp_cyc, rd_cyc, wr_cyc, cycles, wcnt;
    bit done;
    addr = m_a[14:0];
    is_c = ins[15];
    out  = 16'd0;
    if (is_c) begin
      y   = ins[12] ? ram[addr] : m_a;
      out = ref_alu(ins[11:6], m_d, y);
      jmp = (ins[2] && $signed(out) < 0) || (ins[1] && out == 16'd0) || (ins[0] && $signed(out) > 0);
      exp_rd = ins[12] ? mwait + 1 : 0;
      exp_wr = ins[3] ? mwait + 1 : 0;
      new_pc = jmp ? addr : 15'(m_pc + 15'd1);
    end else begin
      exp_rd = 0;
      exp_wr = 0;
      new_pc = 15'(m_pc + 15'd1);
    end
    exp_cyc = fwait + 1 + exp_rd + 1 + exp_wr;

    check("fetch_req", instr_req, 1'b1);
    check("fetch_addr", instr_addr, m_pc);
    check("fetch_memreq", mem_req, 1'b0);
    cycles = 0;
    repeat (fwait) begin
      instr_valid = 1'b0;
      instr_data  = 16'($urandom);
      @(posedge clk); #1;
      cycles++;
    end
    instr_valid = 1'b1;
    instr_data  = ins;
    @(posedge clk); #1;
    cycles++;
    instr_valid = 1'b0;
    instr_data  = 16'($urandom);

    done = 0; rd_cyc = 0; wr_cyc = 0; wcnt = 0;
    while (!done && cycles < 40) begin
      mem_ack = 1'b0;
      if (mem_req) begin
        check("mem_addr", mem_addr, addr);
        if (mem_we) begin
          wr_cyc++;
          check("mem_wdata", mem_wdata, out);
        end else begin
          rd_cyc++;
        end
        if (wcnt == mwait) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_we ? 16'($urandom) : ram[mem_addr];
          wcnt      = 0;
        end else begin
          mem_rdata = 16'($urandom);
          wcnt++;
        end
      end else begin
        check("exec_ireq", instr_req, 1'b0);
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
      end
      #1;
      if (retired) done = 1;
      if (mem_ack && mem_req && mem_we) begin
        last_wdata = mem_wdata;
        last_waddr = mem_addr;
      end
      @(posedge clk); #1;
      cycles++;
    end
    mem_ack = 1'b0;
    check("retired", done, 1'b1);
    check("latency", cycles, exp_cyc);
    check("rd_cycles", rd_cyc, exp_rd);
    check("wr_cycles", wr_cyc, exp_wr);
    check("pc_after", pc, new_pc);
    last_cycles = cycles;

    if (is_c) begin
      if (ins[3]) ram[addr] = out;
      if (ins[5]) m_a = out;
      if (ins[4]) m_d = out;
    end else begin
      m_a = {1'b0, ins[14:0]};
    end
    m_pc = new_pc;
  endtask

  initial begin
    int total;
    logic [15:0] ins;
    reset = 1'b1; instr_valid = 1'b0; instr_data = 16'd0;
    mem_ack = 1'b0; mem_rdata = 16'd0;
    last_wdata = 16'd0; last_waddr = 15'd0; last_cycles = 0;
    for (int i = 0; i < 32768; i++) ram[i] = 16'($urandom);

    // Reset state
    do_reset();
    check("rst_ireq", instr_req, 1'b1);
    check("rst_iaddr", instr_addr, 15'd0);
    check("rst_pc", pc, 15'd0);
    check("rst_mreq", mem_req, 1'b0);
    check("rst_mwe", mem_we, 1'b0);
    check("rst_retired", retired, 1'b0);
    check("rst_halted", halted, 1'b0);

    // @5, D=A, @3, D=D+A -> D=8, pc=4 in 8 cycles
    total = 0;
    do_instr(16'h0005, 0, 0); total += last_cycles;
    do_instr(16'hEC10, 0, 0); total += last_cycles;
    do_instr(16'h0003, 0, 0); total += last_cycles;
    do_instr(16'hE090, 0, 0); total += last_cycles;
    check("prog_cycles", total, 8);
    check("prog_pc", pc, 15'd4);
    do_instr(16'h0032, 0, 0);
    do_instr(16'hE308, 0, 0);
    check("prog_D", last_wdata, 16'd8);

    // M=D with A=7, D=9, ack after 3 wait cycles
    do_instr(16'h0009, 0, 0);
    do_instr(16'hEC10, 0, 0);
    do_instr(16'h0007, 0, 0);
    do_instr(16'hE308, 1, 3);
    check("slow_wr_addr", last_waddr, 15'd7);
    check("slow_wr_data", last_wdata, 16'd9);

    // AM=M+1 with RAM[2]=10
    ram[2] = 16'd10;
    do_instr(16'h0002, 0, 0);
    do_instr(16'hFDE8, 0, 0);
    check("amm1_addr", last_waddr, 15'd2);
    check("amm1_data", last_wdata, 16'd11);
    do_instr(16'hE308, 0, 1);
    check("amm1_A", last_waddr, 15'd11);

    // D;JEQ taken and not taken at pc=4
    do_reset();
    do_instr(16'hEA90, 0, 0);
    do_instr(16'h0000, 0, 0);
    do_instr(16'h0000, 0, 0);
    do_instr(16'h0014, 0, 0);
    do_instr(16'hE302, 0, 0);
    check("jeq_taken", pc, 15'd20);
    do_reset();
    do_instr(16'hEE90, 0, 0);
    do_instr(16'h0000, 0, 0);
    do_instr(16'h0000, 0, 0);
    do_instr(16'h0014, 0, 0);
    do_instr(16'hE302, 0, 0);
    check("jeq_not", pc, 15'd5);

    // PC wrap from the top address
    do_instr(16'h7FFF, 0, 0);
    do_instr(16'hEA87, 0, 0);
    check("jmp_top", pc, 15'h7FFF);
    do_instr(16'h0001, 0, 0);
    check("pc_wrap", pc, 15'd0);

    // Reset during a WRMEM wait
    do_instr(16'h0007, 0, 0);
    do_instr(16'hEC10, 0, 0);
    instr_valid = 1'b1; instr_data = 16'hE308;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    check("wr_wait_req", mem_req, 1'b1);
    check("wr_wait_we", mem_we, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1; mem_ack = 1'b1;
    #1;
    check("rst_wr_noret", retired, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0; mem_ack = 1'b0;
    check("rst_wr_mreq", mem_req, 1'b0);
    check("rst_wr_pc", pc, 15'd0);
    check("rst_wr_ret", retired, 1'b0);
    m_a = 16'd0; m_d = 16'd0; m_pc = 15'd0;
    do_instr(16'hE308, 0, 0);
    check("rst_wr_A", last_waddr, 15'd0);
    check("rst_wr_D", last_wdata, 16'd0);

`ifdef HACK_CPU_ILLEGAL_HALT_EN
    // Illegal C-instruction halts until reset
    do_instr(16'h0005, 0, 0);
    instr_valid = 1'b1; instr_data = 16'h9000;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (3) begin
      check("halt_flag", halted, 1'b1);
      check("halt_ireq", instr_req, 1'b0);
      check("halt_mreq", mem_req, 1'b0);
      check("halt_pc", pc, m_pc);
      @(posedge clk); #1;
    end
    do_reset();
    check("halt_clear", halted, 1'b0);
`endif

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        ins = {1'b0, 15'($urandom)};
      end else begin
        ins = {3'b111, 13'($urandom)};
`ifndef HACK_CPU_ILLEGAL_HALT_EN
        ins[14:13] = 2'($urandom);
`endif
      end
      do_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
